// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the two-master Wishbone arbiter.
package wb_arb_pkg;

    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_DATA_WIDTH = 32;
    localparam int SEL_WIDTH     = WB_DATA_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                     cyc;
        logic                     stb;
        logic                     we;
        logic [SEL_WIDTH-1:0]     sel;
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] dat_w;
    } wb_req_t;

    // A disabled timeout (0 cycles) still needs a one-bit counter to elaborate.
    function automatic int tcnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Per-transaction ack timeout counter: counts BUSY cycles, saturates, flags the last allowed cycle.
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_core,
    input  logic rst_core,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int             TW      = tcnt_width(TIMEOUT_CYCLES);
    localparam logic           TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0]  TC_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]  TC_MAX  = '1;

    logic [TW-1:0] tcnt;

    always_ff @(posedge clk_core) begin
        if (rst_core || clr) begin
            tcnt <= '0;
        end else if (en && (tcnt != TC_MAX)) begin
            tcnt <= tcnt + TW'(1);
        end
    end

    assign expired = TO_EN && (tcnt == TC_LAST);

endmodule

// File: rtl/wb_arbiter_2to1.sv
// Two-master to one-slave classic Wishbone arbiter with round-robin ties,
// whole-transaction ownership, abort handling and ack timeout.
//
//   state | meaning
//   IDLE  | no owner, core bus quiet, arbitrating requests
//   BUSY  | owner's transaction routed to core until ack, abort or timeout
module wb_arbiter_2to1
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_core,
    input  logic                    rst_core,

    input  logic                    m0_cyc,
    input  logic                    m0_stb,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_sel,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_dat_w,
    output logic [DATA_WIDTH-1:0]   m0_dat_r,
    output logic                    m0_ack,
    output logic                    m0_err,

    input  logic                    m1_cyc,
    input  logic                    m1_stb,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_sel,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_dat_w,
    output logic [DATA_WIDTH-1:0]   m1_dat_r,
    output logic                    m1_ack,
    output logic                    m1_err,

    output logic                    core_cyc,
    output logic                    core_stb,
    output logic                    core_we,
    output logic [DATA_WIDTH/8-1:0] core_sel,
    output logic [ADDR_WIDTH-1:0]   core_addr,
    output logic [DATA_WIDTH-1:0]   core_data_out,
    input  logic [DATA_WIDTH-1:0]   core_data_in,
    input  logic                    core_ack,

    output logic [1:0]              grant,
    output logic                    busy
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;

    wb_req_t    m0_req, m1_req, own_req;
    logic       m0_rq, m1_rq;
    logic       tmo_expired, tcnt_clr, tcnt_en, timeout_hit;

    assign m0_req  = {m0_cyc, m0_stb, m0_we, m0_sel, m0_addr, m0_dat_w};
    assign m1_req  = {m1_cyc, m1_stb, m1_we, m1_sel, m1_addr, m1_dat_w};
    assign own_req = owner_q ? m1_req : m0_req;
    assign m0_rq   = m0_cyc & m0_stb;
    assign m1_rq   = m1_cyc & m1_stb;

    wb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_core (clk_core),
        .rst_core (rst_core),
        .clr      (tcnt_clr),
        .en       (tcnt_en),
        .expired  (tmo_expired)
    );

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        tcnt_clr      = 1'b0;
        tcnt_en       = 1'b0;
        timeout_hit   = 1'b0;

        core_cyc      = 1'b0;
        core_stb      = 1'b0;
        core_we       = 1'b0;
        core_sel      = '0;
        core_addr     = '0;
        core_data_out = '0;
        m0_dat_r      = '0;
        m1_dat_r      = '0;
        m0_ack        = 1'b0;
        m1_ack        = 1'b0;
        m0_err        = 1'b0;
        m1_err        = 1'b0;
        grant         = 2'b00;
        busy          = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_rq || m1_rq) begin
                    state_d = BUSY;
                    owner_d = (m0_rq && m1_rq) ? ~last_q : m1_rq;
                end
            end

            BUSY: begin
                // Ack outranks abort and timeout, so an owner dropping cyc on the ack cycle still counts as served.
                if (core_ack) begin
                    state_d  = IDLE;
                    last_d   = owner_q;
                    tcnt_clr = 1'b1;
                end else if (!own_req.cyc) begin
                    state_d  = IDLE;
                    tcnt_clr = 1'b1;
                end else if (tmo_expired) begin
                    state_d     = IDLE;
                    last_d      = owner_q;
                    tcnt_clr    = 1'b1;
                    timeout_hit = 1'b1;
                end else begin
                    tcnt_en = 1'b1;
                end

                core_cyc      = own_req.cyc;
                core_stb      = own_req.stb;
                core_we       = own_req.we;
                core_sel      = own_req.sel;
                core_addr     = own_req.addr;
                core_data_out = own_req.dat_w;
                busy          = 1'b1;

                if (owner_q) begin
                    m1_dat_r = core_data_in;
                    m1_ack   = core_ack;
                    m1_err   = timeout_hit;
                    grant    = 2'b10;
                end else begin
                    m0_dat_r = core_data_in;
                    m0_ack   = core_ack;
                    m0_err   = timeout_hit;
                    grant    = 2'b01;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Self-checking bench for wb_arbiter_2to1: vector table, directed corner cases, random run against a reference model.
module tb_wb_arbiter_2to1;

    localparam int T = 4;

    logic        clk_core = 1'b0;
    logic        rst_core;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_addr, m0_dat_w, m1_addr, m1_dat_w;
    logic [31:0] m0_dat_r, m1_dat_r;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        core_cyc, core_stb, core_we;
    logic [3:0]  core_sel;
    logic [31:0] core_addr, core_data_out, core_data_in;
    logic        core_ack;
    logic [1:0]  grant;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk_core = ~clk_core;

    wb_arbiter_2to1 #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_core      (clk_core),
        .rst_core      (rst_core),
        .m0_cyc        (m0_cyc),
        .m0_stb        (m0_stb),
        .m0_we         (m0_we),
        .m0_sel        (m0_sel),
        .m0_addr       (m0_addr),
        .m0_dat_w      (m0_dat_w),
        .m0_dat_r      (m0_dat_r),
        .m0_ack        (m0_ack),
        .m0_err        (m0_err),
        .m1_cyc        (m1_cyc),
        .m1_stb        (m1_stb),
        .m1_we         (m1_we),
        .m1_sel        (m1_sel),
        .m1_addr       (m1_addr),
        .m1_dat_w      (m1_dat_w),
        .m1_dat_r      (m1_dat_r),
        .m1_ack        (m1_ack),
        .m1_err        (m1_err),
        .core_cyc      (core_cyc),
        .core_stb      (core_stb),
        .core_we       (core_we),
        .core_sel      (core_sel),
        .core_addr     (core_addr),
        .core_data_out (core_data_out),
        .core_data_in  (core_data_in),
        .core_ack      (core_ack),
        .grant         (grant),
        .busy          (busy)
    );

    typedef struct {
        logic       m0r;
        logic       m1r;
        logic [1:0] exp_grant;
    } vec_t;

    vec_t       vecs [8];
    logic [1:0] exp_rr [8];

    // reference model state: owner -1 means idle
    int m_owner;
    int m_last;
    int m_bc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_core);
    endtask

    task automatic set_m0(input logic c, input logic s, input logic w, input logic [3:0] sl,
                          input logic [31:0] a, input logic [31:0] d);
        m0_cyc = c; m0_stb = s; m0_we = w; m0_sel = sl; m0_addr = a; m0_dat_w = d;
    endtask

    task automatic set_m1(input logic c, input logic s, input logic w, input logic [3:0] sl,
                          input logic [31:0] a, input logic [31:0] d);
        m1_cyc = c; m1_stb = s; m1_we = w; m1_sel = sl; m1_addr = a; m1_dat_w = d;
    endtask

    task automatic idle_inputs();
        set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
        core_ack     = 1'b0;
        core_data_in = 32'h0;
    endtask

    task automatic settle();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst_core = 1'b1;
        tick();
        tick();
        rst_core = 1'b0;
    endtask

    task automatic rand_cycle();
        logic        o_cyc, o_stb, o_we, e_busy, e_ack, e_err;
        logic [3:0]  o_sel;
        logic [31:0] o_addr, o_dat;
        logic [14:0] e_ctl, a_ctl;
        logic [1:0]  e_grant;

        tick();
        rst_core = ($urandom_range(0, 99) == 0);
        set_m0($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), $urandom, $urandom);
        set_m1($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), $urandom, $urandom);
        core_ack     = ($urandom_range(0, 4) == 0);
        core_data_in = $urandom;
        sample();

        e_busy  = (m_owner >= 0);
        o_cyc   = (m_owner == 1) ? m1_cyc   : m0_cyc;
        o_stb   = (m_owner == 1) ? m1_stb   : m0_stb;
        o_we    = (m_owner == 1) ? m1_we    : m0_we;
        o_sel   = (m_owner == 1) ? m1_sel   : m0_sel;
        o_addr  = (m_owner == 1) ? m1_addr  : m0_addr;
        o_dat   = (m_owner == 1) ? m1_dat_w : m0_dat_w;
        e_ack   = e_busy && core_ack;
        e_err   = e_busy && !core_ack && o_cyc && (m_bc + 1 == T);
        e_grant = !e_busy ? 2'b00 : (m_owner == 0) ? 2'b01 : 2'b10;

        e_ctl = {e_grant, e_busy,
                 e_ack && m_owner == 0, e_ack && m_owner == 1,
                 e_err && m_owner == 0, e_err && m_owner == 1,
                 e_busy ? {o_cyc, o_stb, o_we, o_sel} : 7'h0};
        a_ctl = {grant, busy, m0_ack, m1_ack, m0_err, m1_err, core_cyc, core_stb, core_we, core_sel};

        chk("rnd_ctl", 32'(a_ctl), 32'(e_ctl));
        chk("rnd_addr", core_addr, e_busy ? o_addr : 32'h0);
        chk("rnd_wdata", core_data_out, e_busy ? o_dat : 32'h0);
        chk("rnd_rdata", m0_dat_r ^ {m1_dat_r[15:0], m1_dat_r[31:16]},
            ((m_owner == 0) ? core_data_in : 32'h0) ^
            ((m_owner == 1) ? {core_data_in[15:0], core_data_in[31:16]} : 32'h0));

        if (rst_core) begin
            m_owner = -1; m_last = 1; m_bc = 0;
        end else if (m_owner < 0) begin
            if ((m0_cyc && m0_stb) && (m1_cyc && m1_stb)) m_owner = 1 - m_last;
            else if (m0_cyc && m0_stb)                    m_owner = 0;
            else if (m1_cyc && m1_stb)                    m_owner = 1;
            m_bc = 0;
        end else if (e_ack) begin
            m_last = m_owner; m_owner = -1;
        end else if (!o_cyc) begin
            m_owner = -1;
        end else if (e_err) begin
            m_last = m_owner; m_owner = -1;
        end else begin
            m_bc++;
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 2'b01};
        vecs[1] = '{1'b1, 1'b1, 2'b10};
        vecs[2] = '{1'b0, 1'b1, 2'b10};
        vecs[3] = '{1'b1, 1'b1, 2'b01};
        vecs[4] = '{1'b1, 1'b0, 2'b01};
        vecs[5] = '{1'b1, 1'b1, 2'b10};
        vecs[6] = '{1'b0, 1'b0, 2'b00};
        vecs[7] = '{1'b1, 1'b1, 2'b01};
        exp_rr  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

        rst_core = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst_core = 1'b0;

        // reset state, with a stray ack and read data on the slave side
        core_ack     = 1'b1;
        core_data_in = 32'hDEADBEEF;
        sample();
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_core", core_addr | core_data_out | 32'({core_cyc, core_stb, core_we, core_sel}), 32'h0);
        chk("reset_dat_r", m0_dat_r | m1_dat_r, 32'h0);
        chk("reset_ack_err", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
        core_ack     = 1'b0;
        core_data_in = 32'h0;

        // arbitration table
        for (int i = 0; i < 8; i++) begin
            tick();
            set_m0(vecs[i].m0r, vecs[i].m0r, 0, 4'hF, 32'h10 + 32'(i), 32'h0);
            set_m1(vecs[i].m1r, vecs[i].m1r, 0, 4'hF, 32'h20 + 32'(i), 32'h0);
            core_ack = 1'b0;
            tick();
            core_ack = (vecs[i].exp_grant != 2'b00);
            sample();
            chk("vec_grant", 32'(grant), 32'(vecs[i].exp_grant));
            chk("vec_ack", 32'({m1_ack, m0_ack}), 32'(vecs[i].exp_grant));
            tick();
            idle_inputs();
            sample();
            chk("vec_gap", 32'(grant), 32'h0);
        end

        // single m0 read, ack on third BUSY cycle
        tick();
        set_m0(1, 1, 0, 4'hF, 32'h100, 32'h0);
        sample();
        chk("rd_cyc_before", 32'(core_cyc), 32'h0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin
                core_ack     = 1'b1;
                core_data_in = 32'hDEADBEEF;
            end
            sample();
            chk("rd_cyc", 32'(core_cyc), 32'h1);
            chk("rd_addr", core_addr, 32'h100);
            chk("rd_grant", 32'(grant), 32'h1);
            chk("rd_m0_ack", 32'(m0_ack), (c == 3) ? 32'h1 : 32'h0);
            chk("rd_m1_ack", 32'(m1_ack), 32'h0);
        end
        chk("rd_data", m0_dat_r, 32'hDEADBEEF);
        chk("rd_m1_dat", m1_dat_r, 32'h0);
        tick();
        idle_inputs();
        sample();
        chk("rd_done_busy", 32'(busy), 32'h0);

        // both masters requesting continuously, slave always acking
        do_reset();
        set_m0(1, 1, 0, 4'hF, 32'hA0, 32'h0);
        set_m1(1, 1, 0, 4'hF, 32'hB0, 32'h0);
        core_ack = 1'b1;
        sample();
        chk("rr_idle_ack", 32'({m0_ack, m1_ack, grant}), 32'h0);
        for (int k = 0; k < 8; k++) begin
            tick();
            sample();
            chk("rr_grant", 32'(grant), 32'(exp_rr[k]));
        end
        settle();

        // m1 write passthrough
        set_m1(1, 1, 1, 4'b0011, 32'h2000_0004, 32'h1234_5678);
        tick();
        sample();
        chk("wr_we_sel", 32'({core_we, core_stb, core_sel}), 32'({1'b1, 1'b1, 4'b0011}));
        chk("wr_addr", core_addr, 32'h2000_0004);
        chk("wr_data", core_data_out, 32'h1234_5678);
        chk("wr_grant", 32'(grant), 32'h2);
        tick();
        core_ack = 1'b1;
        sample();
        chk("wr_ack", 32'({m1_ack, m0_ack}), 32'h2);
        tick();
        settle();

        // timeout with m1 waiting behind m0
        set_m0(1, 1, 0, 4'hF, 32'h300, 32'h0);
        tick();
        set_m1(1, 1, 0, 4'hF, 32'h400, 32'h0);
        for (int c = 1; c <= T; c++) begin
            sample();
            chk("to_m0_err", 32'(m0_err), (c == T) ? 32'h1 : 32'h0);
            chk("to_m1_held", 32'({m1_ack, m1_err, m0_ack}), 32'h0);
            chk("to_grant", 32'(grant), 32'h1);
            if (c < T) tick();
        end
        tick();
        set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
        sample();
        chk("to_idle", 32'({busy, grant}), 32'h0);
        tick();
        sample();
        chk("to_m1_grant", 32'(grant), 32'h2);
        settle();

        // ack on the expiry cycle wins over the error
        set_m0(1, 1, 0, 4'hF, 32'h500, 32'h0);
        tick();
        for (int c = 1; c <= T; c++) begin
            if (c == T) core_ack = 1'b1;
            sample();
            chk("ae_ack", 32'(m0_ack), (c == T) ? 32'h1 : 32'h0);
            chk("ae_err", 32'(m0_err), 32'h0);
            if (c < T) tick();
        end
        tick();
        idle_inputs();
        sample();
        chk("ae_idle", 32'({busy, grant, m0_err}), 32'h0);

        // abort by m1 after two BUSY cycles
        tick();
        set_m1(1, 1, 0, 4'hF, 32'h600, 32'h0);
        tick();
        sample();
        chk("ab_grant", 32'(grant), 32'h2);
        tick();
        tick();
        set_m1(0, 0, 0, 4'hF, 32'h600, 32'h0);
        sample();
        chk("ab_resp", 32'({m1_ack, m1_err, core_cyc}), 32'h0);
        tick();
        sample();
        chk("ab_idle", 32'({busy, grant}), 32'h0);

        // reset in the middle of a transaction
        tick();
        set_m0(1, 1, 0, 4'hF, 32'h700, 32'h0);
        tick();
        sample();
        chk("rs_busy", 32'({core_cyc, grant}), 32'h5);
        rst_core = 1'b1;
        tick();
        sample();
        chk("rs_after", 32'({core_cyc, grant, m0_ack, m0_err}), 32'h0);
        rst_core = 1'b0;
        settle();

        // random run against the reference model
        do_reset();
        m_owner = -1;
        m_last  = 1;
        m_bc    = 0;
        for (int n = 0; n < 2000; n++) begin
            rand_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2to1.md
Name: wb_arbiter_2to1

Overview:
- Two-master to one-slave Wishbone (classic, non-pipelined) arbiter.
- Merges the instruction-side and data-side Wishbone ports, each produced by its own AHB-to-Wishbone bridge behind a dual-port core, onto the single core_* bus that feeds the Controller memory.
- Provides round-robin fairness, whole-transaction ownership, abort handling and a per-transaction ack timeout that returns an error to the owning master.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; sel width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, cycles in BUSY without ack before error; 0 disables the timeout.

Ports:
- clk_core  in  1  clock.
- rst_core  in  1  reset, synchronous, active-high.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 (instruction) request.
- m0_sel  in  4  master 0 byte selects.
- m0_addr  in  32  master 0 address.
- m0_dat_w  in  32  master 0 write data.
- m0_dat_r  out  32  master 0 read data.
- m0_ack, m0_err  out  1 each  master 0 response.
- m1_*  (same set as m0_*)  master 1 (data).
- core_cyc, core_stb, core_we  out  1 each  slave request.
- core_sel  out  4  slave byte selects.
- core_addr  out  32  slave address.
- core_data_out  out  32  slave write data.
- core_data_in  in  32  slave read data.
- core_ack  in  1  slave acknowledge.
- grant  out  2  one-hot current owner, 00 when idle.
- busy  out  1  high in BUSY.

Behaviour:
- State machine has two states, IDLE and BUSY. Registers: state, owner (1 bit), last (1 bit), tcnt (width $clog2(TIMEOUT_CYCLES+1)).
- A master is requesting when its cyc & stb = 1.
- Reset (synchronous):
  - state=IDLE, owner=0, last=1 (master 0 wins the first tie), tcnt=0.
  - Every output is 0; m0_dat_r and m1_dat_r are 0.
- IDLE:
  - core_cyc = core_stb = 0; other core_* outputs are 0.
  - If only one master requests: owner <= that master, go to BUSY at the next edge.
  - If both request: owner <= ~last, go to BUSY.
  - If neither requests: stay in IDLE.
- BUSY (combinational mux on owner):
  - core_cyc/stb/we/sel/addr/data_out = owner's signals.
  - owner's dat_r = core_data_in. Non-owner dat_r = 0, ack = 0, err = 0.
  - owner's ack = core_ack.
- Latency: request seen at edge N drives core_cyc at cycle N+1. Ack passes to the master in the same cycle with zero added latency.
- Leaving BUSY (all go to IDLE at the next edge):
  - core_ack=1: last <= owner, tcnt <= 0. This gives one idle cycle between back-to-back transactions.
  - Owner drops cyc before ack (abort): tcnt <= 0. last is not updated.
  - Timeout: TIMEOUT_CYCLES != 0, tcnt == TIMEOUT_CYCLES-1 and core_ack=0.
    - owner's err = 1 for exactly that cycle.
    - last <= owner, tcnt <= 0.
- Staying in BUSY: in any other BUSY cycle, tcnt <= tcnt+1; it saturates and never wraps.
- Ack and timeout in the same cycle: ack wins, err stays 0.
- Owner drops cyc in the same cycle as core_ack: this is an ack, so last is updated.
- Non-owner requests are held off: no ack is given until that master owns the bus.
- core_ack in IDLE is ignored; no master sees it.
- rst_core during BUSY: at the next edge state returns to IDLE and core_cyc=0; the in-flight master receives neither ack nor err.
- grant = one-hot of owner in BUSY, 00 in IDLE. busy = (state == BUSY).

Decomposition:
- Package wb_arb_pkg holds:
  - typedef arb_state_e {IDLE, BUSY};
  - localparam SEL_WIDTH = DATA_WIDTH/8;
  - a packed struct wb_req_t {cyc, stb, we, sel, addr, dat_w}.
- Sub-module wb_arb_timeout: the counter, its clear/enable inputs and the expiry output.
- Arbitration, FSM and muxing stay in the top module.

Test Plan:
- Single request: m0 read, addr=0x100; slave acks on the 3rd BUSY cycle with data 0xDEADBEEF -> core_cyc high from cycle N+1, m0_ack=1 with m0_dat_r=0xDEADBEEF in that cycle, m1_ack=0 throughout, grant=01 during BUSY.
- Simultaneous requests after reset: m0 and m1 both request continuously, slave acks each after 1 cycle -> grant order m0, m1, m0, m1, one IDLE cycle between grants.
- Write passthrough: m1 write, addr=0x2000_0004, sel=4'b0011, data=0x1234_5678 -> core_we=1, core_sel=0011, core_addr and core_data_out match the request exactly while BUSY.
- Timeout: TIMEOUT_CYCLES=4, slave never acks -> m0_err=1 on exactly the 4th BUSY cycle, IDLE the next cycle, waiting m1 granted after that.
- Ack on the expiry cycle: TIMEOUT_CYCLES=4, core_ack=1 on the 4th BUSY cycle -> m0_ack=1, m0_err=0.
- Abort and reset: m1 drops cyc after 2 BUSY cycles -> IDLE, no ack/err. Then rst_core asserted mid-BUSY -> core_cyc=0 from the next cycle, grant=00.
